// File: rtl/hs_pkg.sv
// Shared constants and state encoding for the Horn-Schunck iteration sequencer.
// Frame geometry defaults here; the top and the bench may override them.
package hs_pkg;

  localparam int IMAGE_WIDTH   = 584;
  localparam int IMAGE_HEIGHT  = 388;
  localparam int IMAGE_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_WIDTH    = 18;
  localparam int ITER_WIDTH    = 8;
  localparam int DRAIN_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hs_raster_counter.sv
// Raster address counter: counts 0..IMAGE_SIZE-1 while enabled and wraps to 0,
// flagging the last address so the owner can detect end of frame.
module hs_raster_counter #(
  parameter int ADDR_WIDTH = hs_pkg::ADDR_WIDTH,
  parameter int IMAGE_SIZE = hs_pkg::IMAGE_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  tc
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_SIZE - 1);

  assign tc = (count == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/hs_iter_sequencer.sv
// Runs hsOptFlowTop for a programmable number of Horn-Schunck iterations:
// each iteration streams the frame buffer into the core, then captures its output.
//
// state | meaning
// IDLE  | waiting for io_start
// FEED  | raster-reading the frame buffer into the core
// DRAIN | feed complete; waiting for / finishing the output capture
module hs_iter_sequencer #(
  parameter int IMAGE_WIDTH   = hs_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT  = hs_pkg::IMAGE_HEIGHT,
  parameter int ADDR_WIDTH    = hs_pkg::ADDR_WIDTH,
  parameter int ITER_WIDTH    = hs_pkg::ITER_WIDTH,
  parameter int DRAIN_TIMEOUT = hs_pkg::DRAIN_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic                  io_abort,
  input  logic [ITER_WIDTH-1:0] io_num_iters,
  output logic                  io_rd_en,
  output logic [ADDR_WIDTH-1:0] io_rd_addr,
  output logic                  io_core_frame_sync,
  output logic                  io_first_iter,
  input  logic                  io_core_frame_sync_out,
  output logic                  io_wr_en,
  output logic [ADDR_WIDTH-1:0] io_wr_addr,
  output logic [ITER_WIDTH-1:0] io_iter,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_error
);

  import hs_pkg::*;

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int TW         = $clog2(DRAIN_TIMEOUT + 1);

  hs_state_e             state;
  logic [ITER_WIDTH-1:0] num_iters_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [TW-1:0]         drain_timer;
  logic                  capturing;
  logic                  core_sync_q;
  logic                  first_iter_q;
  logic                  done_q;
  logic                  error_q;

  logic                  feed_active;
  logic                  cap_accept;
  logic                  wr_en;
  logic                  last_write;
  logic                  rd_tc;
  logic                  wr_tc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign feed_active = (state == FEED);
  // Capture starts combinationally so write address 0 lines up with frame_sync_out;
  // a repeat pulse while already capturing is dropped.
  assign cap_accept  = io_core_frame_sync_out && (state != IDLE) && !capturing;
  assign wr_en       = capturing || cap_accept;
  assign last_write  = wr_en && wr_tc;

  hs_raster_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMAGE_SIZE (IMAGE_SIZE)
  ) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .start (io_abort),
    .en    (feed_active),
    .count (rd_addr),
    .tc    (rd_tc)
  );

  hs_raster_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMAGE_SIZE (IMAGE_SIZE)
  ) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .start (io_abort),
    .en    (wr_en),
    .count (wr_addr),
    .tc    (wr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      num_iters_q  <= '0;
      iter_q       <= '0;
      drain_timer  <= '0;
      capturing    <= 1'b0;
      core_sync_q  <= 1'b0;
      first_iter_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else if (io_abort) begin
      state        <= IDLE;
      capturing    <= 1'b0;
      core_sync_q  <= 1'b0;
      first_iter_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      core_sync_q <= feed_active && (rd_addr == '0);

      if (cap_accept) capturing <= 1'b1;
      if (last_write) capturing <= 1'b0;

      if (last_write) begin
        first_iter_q <= 1'b0;
        if (iter_q == num_iters_q - 1'b1) begin
          done_q <= 1'b1;
          state  <= IDLE;
        end else begin
          iter_q <= iter_q + 1'b1;
          state  <= FEED;
        end
      end else begin
        case (state)
          IDLE: begin
            if (io_start) begin
              error_q <= 1'b0;
              if (io_num_iters == '0) begin
                done_q <= 1'b1;
              end else begin
                num_iters_q  <= io_num_iters;
                iter_q       <= '0;
                first_iter_q <= 1'b1;
                state        <= FEED;
              end
            end
          end
          FEED: begin
            if (rd_tc) begin
              state       <= DRAIN;
              drain_timer <= TW'(DRAIN_TIMEOUT - 1);
            end
          end
          DRAIN: begin
            // Timer only matters until the core's output frame has started.
            if (!capturing && !cap_accept) begin
              if (drain_timer == TW'(1)) begin
                error_q      <= 1'b1;
                first_iter_q <= 1'b0;
                state        <= IDLE;
              end else begin
                drain_timer <= drain_timer - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign io_rd_en           = feed_active;
  assign io_rd_addr         = rd_addr;
  assign io_core_frame_sync = core_sync_q;
  assign io_first_iter      = first_iter_q;
  assign io_wr_en           = wr_en;
  assign io_wr_addr         = wr_addr;
  assign io_iter            = iter_q;
  assign io_busy            = (state != IDLE);
  assign io_done            = done_q;
  assign io_error           = error_q;

endmodule

// File: tb/tb_hs_iter_sequencer.sv
// Scoreboard bench for hs_iter_sequencer on a reduced frame, with a simple core model.
module tb_hs_iter_sequencer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 6;
  localparam int IW = hs_pkg::ITER_WIDTH;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_abort;
  logic [IW-1:0] io_num_iters;
  logic          io_rd_en;
  logic [AW-1:0] io_rd_addr;
  logic          io_core_frame_sync;
  logic          io_first_iter;
  logic          fso;
  logic          io_wr_en;
  logic [AW-1:0] io_wr_addr;
  logic [IW-1:0] io_iter;
  logic          io_busy;
  logic          io_done;
  logic          io_error;

  hs_iter_sequencer #(
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .ADDR_WIDTH    (AW),
    .ITER_WIDTH    (IW),
    .DRAIN_TIMEOUT (TO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_start               (io_start),
    .io_abort               (io_abort),
    .io_num_iters           (io_num_iters),
    .io_rd_en               (io_rd_en),
    .io_rd_addr             (io_rd_addr),
    .io_core_frame_sync     (io_core_frame_sync),
    .io_first_iter          (io_first_iter),
    .io_core_frame_sync_out (fso),
    .io_wr_en               (io_wr_en),
    .io_wr_addr             (io_wr_addr),
    .io_iter                (io_iter),
    .io_busy                (io_busy),
    .io_done                (io_done),
    .io_error               (io_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cy;
    int addr;
    int iter;
    bit first;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  sync_q[$];
  int  done_q[$];
  int  err_q[$];
  int  core_delays[$];
  int  dly[$];
  int  spur_off = 0;
  bit  mon_on = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic void check(string name, bit ok, string msg);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, msg);
    end
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int t);
    while (cyc < t) next_cyc();
  endtask

  task automatic wait_neg(input int t);
    forever begin
      @(negedge clk);
      if (cyc >= t) break;
    end
  endtask

  // Core model: frame_sync_out d cycles after the feed's first read (d-1 after frame_sync).
  initial begin
    int d;
    fso = 1'b0;
    forever begin
      @(negedge clk);
      if (io_core_frame_sync === 1'b1) begin
        d = (core_delays.size() > 0) ? core_delays.pop_front() : -1;
        if (d >= 2) begin
          repeat (d - 1) @(posedge clk);
          #1 fso = 1'b1;
          @(posedge clk);
          #1 fso = 1'b0;
          if (spur_off > 0) begin
            repeat (spur_off - 1) @(posedge clk);
            #1 fso = 1'b1;
            @(posedge clk);
            #1 fso = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every presented output event is matched against the scoreboard.
  initial begin
    ev_t e;
    int  t;
    bit  prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (io_rd_en) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1'b0, $sformatf("rd_en with addr %0d, none expected", io_rd_addr));
          else begin
            e = rd_q.pop_front();
            check("rd", cyc == e.cy && int'(io_rd_addr) == e.addr && int'(io_iter) == e.iter && io_first_iter == e.first,
                  $sformatf("got cyc %0d addr %0d iter %0d first %0b, want cyc %0d addr %0d iter %0d first %0b",
                            cyc, io_rd_addr, io_iter, io_first_iter, e.cy, e.addr, e.iter, e.first));
          end
        end
        if (io_wr_en) begin
          if (wr_q.size() == 0) check("wr_unexpected", 1'b0, $sformatf("wr_en with addr %0d, none expected", io_wr_addr));
          else begin
            e = wr_q.pop_front();
            check("wr", cyc == e.cy && int'(io_wr_addr) == e.addr && int'(io_iter) == e.iter && io_first_iter == e.first,
                  $sformatf("got cyc %0d addr %0d iter %0d first %0b, want cyc %0d addr %0d iter %0d first %0b",
                            cyc, io_wr_addr, io_iter, io_first_iter, e.cy, e.addr, e.iter, e.first));
          end
        end
        if (io_core_frame_sync) begin
          t = (sync_q.size() > 0) ? sync_q.pop_front() : -1;
          check("core_sync", cyc == t, $sformatf("got at cyc %0d, want cyc %0d", cyc, t));
        end
        if (io_done) begin
          t = (done_q.size() > 0) ? done_q.pop_front() : -1;
          check("done", cyc == t, $sformatf("got at cyc %0d, want cyc %0d", cyc, t));
        end
        if (io_error && !prev_err) begin
          t = (err_q.size() > 0) ? err_q.pop_front() : -1;
          check("error_rise", cyc == t, $sformatf("got at cyc %0d, want cyc %0d", cyc, t));
        end
      end
      prev_err = io_error;
    end
  end

  function automatic void push_ev(ref ev_t q[$], input int cy, input int a, input int k);
    ev_t e;
    e.cy = cy; e.addr = a; e.iter = k; e.first = (k == 0);
    q.push_back(e);
  endfunction

  // Timeline model: iteration k feeds from f, output arrives at c = f + d,
  // next feed starts at c + N; done follows the last write; a missing output
  // raises error TO cycles after the last read. Events past a cut are dropped.
  task automatic run_seq(input int num, input int cut_iter, input int cut_addr,
                         input bit cut_reset, input bit poke);
    int s, f, c, d, tcut, t_end;
    bit was_cut;
    tcut  = 1 << 30;
    t_end = 0;
    next_cyc();
    s = cyc;
    f = s + 1;
    if (num == 0) begin
      done_q.push_back(s + 1);
      t_end = s + 1;
    end
    for (int k = 0; k < num; k++) begin
      if (k == cut_iter) tcut = f + cut_addr;
      for (int a = 0; a < N; a++) if (f + a <= tcut) push_ev(rd_q, f + a, a, k);
      if (f + 1 <= tcut) sync_q.push_back(f + 1);
      d = (k < dly.size()) ? dly[k] : -1;
      core_delays.push_back(d);
      if (d < 2 || d > N + TO - 2) begin
        t_end = f + N - 1 + TO;
        if (t_end <= tcut) err_q.push_back(t_end);
        break;
      end
      c = f + d;
      for (int a = 0; a < N; a++) if (c + a <= tcut) push_ev(wr_q, c + a, a, k);
      f = c + N;
      t_end = f;
      if (k == num - 1 && f <= tcut) done_q.push_back(f);
    end
    was_cut = (t_end > tcut);

    io_num_iters = IW'(num);
    io_start     = 1'b1;
    next_cyc();
    io_start     = 1'b0;
    io_num_iters = IW'($urandom);
    wait_neg(s + 1);
    check("error_cleared", io_error == 1'b0, $sformatf("io_error %0b, want 0", io_error));
    if (num == 0) check("zero_busy", io_busy == 1'b0, $sformatf("io_busy %0b, want 0", io_busy));

    if (poke) begin
      wait_pos(s + 6);
      io_start     = 1'b1;
      io_num_iters = IW'($urandom_range(1, 255));
      next_cyc();
      io_start     = 1'b0;
    end

    if (was_cut) begin
      wait_pos(tcut);
      if (cut_reset) reset = 1'b1;
      else           io_abort = 1'b1;
      next_cyc();
      reset    = 1'b0;
      io_abort = 1'b0;
      wait_neg(tcut + 1);
      if (cut_reset)
        check("reset_midrun", {io_rd_en, io_rd_addr, io_core_frame_sync, io_first_iter, io_wr_en,
                               io_wr_addr, io_iter, io_busy, io_done, io_error} == '0,
              $sformatf("rd_en %0b rd_addr %0d sync %0b first %0b wr_en %0b wr_addr %0d iter %0d busy %0b done %0b err %0b, want all 0",
                        io_rd_en, io_rd_addr, io_core_frame_sync, io_first_iter, io_wr_en, io_wr_addr,
                        io_iter, io_busy, io_done, io_error));
      else
        check("abort_idle", {io_rd_en, io_wr_en, io_core_frame_sync, io_busy, io_done} == 5'b0,
              $sformatf("rd_en %0b wr_en %0b sync %0b busy %0b done %0b, want all 0",
                        io_rd_en, io_wr_en, io_core_frame_sync, io_busy, io_done));
      t_end = tcut;
    end

    wait_neg(t_end + 3);
    check("idle_after_run", io_busy == 1'b0, $sformatf("io_busy %0b, want 0", io_busy));
    check("scoreboard_empty", rd_q.size() + wr_q.size() + sync_q.size() + done_q.size() + err_q.size() == 0,
          $sformatf("left rd %0d wr %0d sync %0d done %0d err %0d, want 0",
                    rd_q.size(), wr_q.size(), sync_q.size(), done_q.size(), err_q.size()));
    rd_q.delete(); wr_q.delete(); sync_q.delete(); done_q.delete(); err_q.delete();
    core_delays.delete();
    if (was_cut) repeat (2 * N + TO + 10) next_cyc();
  endtask

  task automatic rand_dly(input int n);
    dly.delete();
    for (int i = 0; i < n; i++) dly.push_back($urandom_range(2, N + TO));
  endtask

  initial begin
    reset        = 1'b1;
    io_start     = 1'b0;
    io_abort     = 1'b0;
    io_num_iters = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_vals", {io_rd_en, io_rd_addr, io_core_frame_sync, io_first_iter, io_wr_en,
                         io_wr_addr, io_iter, io_busy, io_done, io_error} == '0,
          $sformatf("rd_en %0b rd_addr %0d sync %0b first %0b wr_en %0b wr_addr %0d iter %0d busy %0b done %0b err %0b, want all 0",
                    io_rd_en, io_rd_addr, io_core_frame_sync, io_first_iter, io_wr_en, io_wr_addr,
                    io_iter, io_busy, io_done, io_error));
    mon_on = 1'b1;

    // single iteration, output 20 cycles after pixel 0
    dly.delete(); dly.push_back(20);
    run_seq(1, -1, 0, 1'b0, 1'b0);

    // three iterations: output during feed, during drain, and near last read;
    // spurious frame_sync_out in capture and io_start during feed
    dly.delete();
    dly.push_back(20);
    dly.push_back($urandom_range(N, N + TO - 2));
    dly.push_back($urandom_range(2, N - 1));
    spur_off = $urandom_range(1, N - 1);
    run_seq(3, -1, 0, 1'b0, 1'b1);
    spur_off = 0;

    run_seq(0, -1, 0, 1'b0, 1'b0);

    // drain timeout: never, one cycle too late, then exactly in time
    dly.delete(); dly.push_back(-1);
    run_seq(1, -1, 0, 1'b0, 1'b0);
    check("error_sticky", io_error == 1'b1, $sformatf("io_error %0b, want 1", io_error));
    dly.delete(); dly.push_back(N + TO - 1);
    run_seq(1, -1, 0, 1'b0, 1'b0);
    dly.delete(); dly.push_back(N + TO - 2); dly.push_back(N);
    run_seq(2, -1, 0, 1'b0, 1'b0);

    // abort at read address 20 of iteration 1, then a clean run
    rand_dly(3);
    run_seq(3, 1, 20, 1'b0, 1'b0);
    rand_dly(2);
    run_seq(2, -1, 0, 1'b0, 1'b0);

    // reset mid-run, then a clean run
    rand_dly(2);
    run_seq(2, 0, 30, 1'b1, 1'b0);
    rand_dly(2);
    run_seq(2, -1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_dly(3);
      run_seq($urandom_range(1, 3), -1, 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cyc %0d, want finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hs_iter_sequencer.md
Name: hs_iter_sequencer

Overview:
- Controller that runs hsOptFlowTop for a programmable number of Horn-Schunck iterations over one frame pair.
- Per iteration it raster-scans the frame buffer (read address/enable), drives the core's frame_sync input, then captures the core's output frame into the flow buffer (write address/enable).
- Sits between the frame/flow buffer memories and hsOptFlowTop. Iterations are strictly serialized: iteration k+1 feed starts only after iteration k output is fully written.

Parameters:
- IMAGE_WIDTH, 584, pixels per line
- IMAGE_HEIGHT, 388, lines per frame; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT
- ADDR_WIDTH, 18, buffer address width; must satisfy 2^ADDR_WIDTH >= IMAGE_SIZE
- ITER_WIDTH, 8, width of iteration count
- DRAIN_TIMEOUT, 4096, maximum cycles from end of feed to first core frame_sync_out

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- io_start  in  1  one-cycle request to begin a run; honoured only in IDLE
- io_abort  in  1  abandon the current run
- io_num_iters  in  ITER_WIDTH  iterations to run; sampled on accepted io_start
- io_rd_en  out  1  frame buffer read enable (1-cycle read latency)
- io_rd_addr  out  ADDR_WIDTH  frame buffer read address
- io_core_frame_sync  out  1  to core io_frame_sync_in
- io_first_iter  out  1  high throughout iteration 0; core uses zero initial flow
- io_core_frame_sync_out  in  1  from core io_frame_sync_out
- io_wr_en  out  1  flow buffer write enable
- io_wr_addr  out  ADDR_WIDTH  flow buffer write address
- io_iter  out  ITER_WIDTH  index of the current iteration
- io_busy  out  1  high in any state other than IDLE
- io_done  out  1  one-cycle pulse on successful completion
- io_error  out  1  sticky drain-timeout flag; cleared by the next accepted io_start

Behaviour:
- Reset: state IDLE. All outputs are 0, and all counters are 0.
- State IDLE:
  - io_start with io_num_iters==0: no feed, and io_done pulses the next cycle.
  - io_start with io_num_iters>0: latch the count, clear io_error and io_iter, go to FEED.
- State FEED:
  - io_rd_en=1 with io_rd_addr = 0,1,…,IMAGE_SIZE-1 on consecutive cycles; no stalls.
  - io_core_frame_sync=1 exactly one cycle after rd_addr 0 is issued, aligned with pixel 0 data. It is 0 otherwise.
  - After issuing IMAGE_SIZE-1, go to DRAIN and start the timeout counter.
- State DRAIN:
  - Wait for io_core_frame_sync_out. If the timeout counter reaches DRAIN_TIMEOUT first, set io_error and go to IDLE with no done pulse.
  - io_core_frame_sync_out is allowed to arrive while FEED is still running. The sequencer latches it, and write capture starts in that same cycle.
- Write capture:
  - io_wr_en=1 on the frame_sync_out cycle and on the following IMAGE_SIZE-1 cycles.
  - io_wr_addr runs 0 to IMAGE_SIZE-1, with address 0 coincident with frame_sync_out.
  - A repeated frame_sync_out during capture is ignored.
- After the last write:
  - If io_iter == num_iters-1: pulse io_done and go to IDLE.
  - Otherwise: io_iter+1, io_first_iter=0, and go to FEED on the next cycle.
- Address counters wrap to 0 at IMAGE_SIZE-1 and never exceed it.
- io_abort has priority over every transition. Next cycle: IDLE, rd_en/wr_en/core_frame_sync=0, no done pulse, io_error unchanged.
- io_start while busy is ignored.
- Reset mid-run has the same effect as the reset values above.

Decomposition:
- Shared package hs_pkg:
  - IMAGE_WIDTH/HEIGHT/SIZE and the ADDR_WIDTH constants, also used by the testbench and the top.
  - State enum encoding: IDLE, FEED, DRAIN.
- One sub-module, hs_raster_counter: an ADDR_WIDTH up-counter with start/enable, a terminal-count flag and wrap at IMAGE_SIZE-1. It is instantiated twice, once for the read address and once for the write address.

Test Plan:
- Single iteration (num_iters=1; model core = frame_sync_out 20 cycles after feed pixel 0):
  - Exactly 226592 rd_en cycles, addr 0 to 226591.
  - One core_frame_sync, one cycle after rd_addr 0.
  - 226592 wr_en cycles, wr_addr 0 at frame_sync_out.
  - One io_done; io_first_iter high throughout.
- Three iterations (num_iters=3):
  - io_iter steps 0, 1, 2.
  - The FEED of iteration k+1 starts exactly one cycle after the last write of iteration k.
  - io_first_iter is high only during iteration 0.
  - io_done pulses once, after the third capture.
- Zero iterations (num_iters=0): io_done the cycle after start, no rd_en or wr_en, and io_busy never asserts.
- Drain timeout (model core never asserts frame_sync_out):
  - io_error set DRAIN_TIMEOUT cycles after the last read; return to IDLE with no done.
  - Then io_start clears io_error.
- Abort at rd_addr 1000 in iteration 1:
  - Next cycle rd_en=0, io_busy=0, no done.
  - A subsequent start runs cleanly from iter 0.
- io_start during FEED, and a spurious frame_sync_out during capture: both ignored, and the address sequence is unchanged.
